add: RTL and testbench
======================

// Module: add
// PURPOSE
//   Registered two's-complement / unsigned adder with ALU status flags.
//   Adds two WIDTH-bit operands; registers the sum with carry, sign, parity,
//   zero and overflow flags on the next rising clock edge.
//   Used as the add stage of a simple datapath/ALU; downstream logic
//   consumes Z and flags when out_valid is high.
// PARAMETERS
//   WIDTH  16  operand and sum width in bits (WIDTH >= 2)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      X/Y qualify this cycle; capture on rising edge
//   X          in   WIDTH  operand A
//   Y          in   WIDTH  operand B
//   Z          out  WIDTH  registered sum X+Y, modulo 2^WIDTH
//   carry      out  1      carry-out of bit WIDTH-1 (unsigned overflow)
//   sign       out  1      Z[WIDTH-1]
//   parity     out  1      even-parity flag: 1 when Z has an even number of 1s (~^Z)
//   zero       out  1      1 when Z == 0
//   overflow   out  1      signed overflow of X+Y
//   out_valid  out  1      Z and flags hold a fresh result
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - rst_n low (any time, no clock needed): Z=0, carry=0, sign=0, zero=0,
//     overflow=0, out_valid=0, parity=0. Outputs are registers, so reset
//     forces them directly. They are not recomputed from Z=0.
//   - Reset released mid-stream: first capture is on the first rising edge
//     with rst_n high and in_valid high; no stale result emerges.
//   - Datapath: {c,S} = {1'b0,X} + {1'b0,Y} ((WIDTH+1)-bit, no carry-in).
//   - Flags are computed from S of the same operation:
//     carry = c
//     sign = S[WIDTH-1]
//     parity = ~^S
//     zero = ~|S
//     overflow = (X[MSB]&Y[MSB]&~S[MSB]) | (~X[MSB]&~Y[MSB]&S[MSB])
//   - Latency: exactly 1 cycle. Edge with in_valid=1 loads Z and all flags
//     and sets out_valid=1.
//   - Edge with in_valid=0: out_valid<=0; Z and flags HOLD their last value.
//   - No backpressure: result overwritten every valid cycle; full throughput.
//   - Z and all flags always update together; never partially updated.
//   - Wrap-around: sum beyond 2^WIDTH-1 wraps; carry=1 reports it.
//   - Operands changing between edges have no effect until the next
//     rising edge; there is no combinational input-to-output path.
// TESTING  (WIDTH=16, in_valid=1, check one cycle after capture)
//   X=0001,Y=0002 -> Z=0003 carry0 sign0 parity1 zero0 ovf0
//   X=FFFF,Y=0001 -> Z=0000 carry1 sign0 parity1 zero1 ovf0
//   X=7FFF,Y=0001 -> Z=8000 carry0 sign1 parity0 zero0 ovf1
//   X=8000,Y=FFFF -> Z=7FFF carry1 sign0 parity0 zero0 ovf1
//   X=5555,Y=AAAA (also 3F3F+C0C0) -> Z=FFFF carry0 sign1 parity1 ovf0;
//     then in_valid=0 -> out_valid0, Z holds FFFF
//   Assert rst_n=0 between clock edges mid-stream -> all outputs 0 at once;
//     release rst_n, 0000+0000 -> Z=0000 zero1 parity1 out_valid1

Source files
------------

// File: rtl/add.sv
// Registered adder with ALU status flags: one-cycle latency, sum and flags
// always captured together, result held while in_valid is low.
module add #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Z,
   output logic             carry,
   output logic             sign,
   output logic             parity,
   output logic             zero,
   output logic             overflow,
   output logic             out_valid
);

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic             carry;
      logic             sign;
      logic             parity;
      logic             zero;
      logic             overflow;
   } res_t;

   logic [WIDTH:0] sum;
   res_t           calc;
   res_t           res_d, res_q;
   logic           valid_d, valid_q;

   // Flags derive from the fresh sum, never from the registered Z.
   always_comb begin
      sum           = {1'b0, X} + {1'b0, Y};
      calc.z        = sum[WIDTH-1:0];
      calc.carry    = sum[WIDTH];
      calc.sign     = sum[WIDTH-1];
      calc.parity   = ~^sum[WIDTH-1:0];
      calc.zero     = ~|sum[WIDTH-1:0];
      calc.overflow = (X[WIDTH-1] & Y[WIDTH-1] & ~sum[WIDTH-1]) |
                      (~X[WIDTH-1] & ~Y[WIDTH-1] & sum[WIDTH-1]);
   end

   always_comb begin
      res_d   = res_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d = calc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign Z         = res_q.z;
   assign carry     = res_q.carry;
   assign sign      = res_q.sign;
   assign parity    = res_q.parity;
   assign zero      = res_q.zero;
   assign overflow  = res_q.overflow;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: arithmetic reference model compared every
// cycle, plus literal vectors and a mid-stream asynchronous reset.
module tb_add;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  X, Y, Z;
   logic          carry, sign, parity, zero, overflow, out_valid;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   add #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .X(X), .Y(Y), .Z(Z),
      .carry(carry), .sign(sign), .parity(parity), .zero(zero),
      .overflow(overflow), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference model: integer arithmetic on the operands.
   logic [W-1:0] m_z;
   logic         m_c, m_s, m_p, m_zr, m_o, m_v;

   always @(posedge clk or negedge rst_n) begin
      int unsigned u, r;
      int          s;
      if (!rst_n) begin
         m_z <= '0; m_c <= 0; m_s <= 0; m_p <= 0; m_zr <= 0; m_o <= 0; m_v <= 0;
      end else begin
         m_v <= in_valid;
         if (in_valid) begin
            u = int'(X) + int'(Y);
            r = u % (2 ** W);
            s = int'($signed(X)) + int'($signed(Y));
            m_z  <= r[W-1:0];
            m_c  <= (u >= 2 ** W);
            m_s  <= (r >= 2 ** (W - 1));
            m_p  <= ($countones(r) % 2) == 0;
            m_zr <= (r == 0);
            m_o  <= (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("m.out_valid", 32'(out_valid), 32'(m_v));
         chk("m.Z",         32'(Z),         32'(m_z));
         chk("m.carry",     32'(carry),     32'(m_c));
         chk("m.sign",      32'(sign),      32'(m_s));
         chk("m.parity",    32'(parity),    32'(m_p));
         chk("m.zero",      32'(zero),      32'(m_zr));
         chk("m.overflow",  32'(overflow),  32'(m_o));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, ".Z"}, 32'(Z), 0);
      chk({tag, ".flags"}, 32'({carry, sign, parity, zero, overflow}), 0);
      chk({tag, ".out_valid"}, 32'(out_valid), 0);
   endtask

   task automatic lit(input logic [W-1:0] x, y, ez, input logic ec, es, ep, ezr, eo);
      in_valid = 1'b1; X = x; Y = y;
      @(posedge clk); #2;
      chk("lit.Z", 32'(Z), 32'(ez));
      chk("lit.carry", 32'(carry), 32'(ec));
      chk("lit.sign", 32'(sign), 32'(es));
      chk("lit.parity", 32'(parity), 32'(ep));
      chk("lit.zero", 32'(zero), 32'(ezr));
      chk("lit.overflow", 32'(overflow), 32'(eo));
      chk("lit.out_valid", 32'(out_valid), 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; X = '0; Y = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      started = 1'b1;

      lit(16'h0001, 16'h0002, 16'h0003, 0, 0, 1, 0, 0);
      lit(16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 1, 0);
      lit(16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 0, 1);
      lit(16'h8000, 16'hFFFF, 16'h7FFF, 1, 0, 0, 0, 1);
      lit(16'h3F3F, 16'hC0C0, 16'hFFFF, 0, 1, 1, 0, 0);
      lit(16'h5555, 16'hAAAA, 16'hFFFF, 0, 1, 1, 0, 0);

      // Idle cycle: result holds, valid drops.
      in_valid = 1'b0; X = 16'h1234; Y = 16'h4321;
      @(posedge clk); #2;
      chk("hold.out_valid", 32'(out_valid), 0);
      chk("hold.Z", 32'(Z), 32'h0000FFFF);
      chk("hold.sign", 32'(sign), 1);

      repeat (400) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 3) != 0);
         X = pick();
         Y = pick();
      end

      // Asynchronous reset between edges.
      in_valid = 1'b1; X = 16'h7FFF; Y = 16'h7FFF;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk); #1;
      chk_all_zero("rst_held");
      rst_n = 1'b1;
      lit(16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);

      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
